// File: rtl/muldiv_if.sv
// Bus between the EX stage, the multiplier/divider units and the mul/div sequencer.
// The sequencer attaches through the slave modport; the pipeline/unit side uses master.
interface muldiv_if;
    localparam int unsigned XLEN = 32;

    logic              op_valid;
    logic [1:0]        op;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic              hilo_read;
    logic              flush;
    logic              mult_done;
    logic [2*XLEN-1:0] mult_result;
    logic              div_done;
    logic [2*XLEN-1:0] div_result;

    logic              mult_start;
    logic              div_start;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic              op_signed;
    logic              stall;
    logic              hi_we;
    logic              lo_we;
    logic [XLEN-1:0]   hi_wdata;
    logic [XLEN-1:0]   lo_wdata;
    logic              timeout_err;
    logic              busy;

    modport master (
        output op_valid, op, rs_data, rt_data, hilo_read, flush,
               mult_done, mult_result, div_done, div_result,
        input  mult_start, div_start, op_a, op_b, op_signed, stall,
               hi_we, lo_we, hi_wdata, lo_wdata, timeout_err, busy
    );

    modport slave (
        input  op_valid, op, rs_data, rt_data, hilo_read, flush,
               mult_done, mult_result, div_done, div_result,
        output mult_start, div_start, op_a, op_b, op_signed, stall,
               hi_we, lo_we, hi_wdata, lo_wdata, timeout_err, busy
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle multiplier/divider feeding HI/LO.
// Latches operands, pulses the selected unit's start, waits for done (with a
// watchdog), then performs one HI/LO write. Stalls the pipeline while busy.
// Optional: `define DIV_ZERO_BYPASS_EN to resolve divide-by-zero without the divider.
module muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT) + 1
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        WRITE    = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              mult_start_n, div_start_n, we_n, tmo_n;
    logic [XLEN-1:0]   op_a_n, op_b_n, hi_n, lo_n;
    logic              op_signed_n;
    logic              unit_done;
    logic [2*XLEN-1:0] unit_res;

    // Stall only while an op is in flight; HI/LO become readable after WRITE.
    assign bus.stall = (state != IDLE) && (bus.op_valid || bus.hilo_read);

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        mult_start_n = 1'b0;
        div_start_n  = 1'b0;
        we_n         = 1'b0;
        tmo_n        = 1'b0;
        op_a_n       = bus.op_a;
        op_b_n       = bus.op_b;
        op_signed_n  = bus.op_signed;
        hi_n         = bus.hi_wdata;
        lo_n         = bus.lo_wdata;
        unit_done    = (state == DIV_BUSY) ? bus.div_done   : bus.mult_done;
        unit_res     = (state == DIV_BUSY) ? bus.div_result : bus.mult_result;

        case (state)
            IDLE: begin
                if (bus.op_valid && !bus.flush) begin
                    op_a_n      = bus.rs_data;
                    op_b_n      = bus.rt_data;
                    op_signed_n = !bus.op[0];
                    cnt_n       = '0;
`ifdef DIV_ZERO_BYPASS_EN
                    if (bus.op[1] && (bus.rt_data == '0)) begin
                        state_n = WRITE;
                        we_n    = 1'b1;
                        hi_n    = bus.rs_data;
                        lo_n    = '1;
                    end else if (bus.op[1]) begin
                        state_n     = DIV_BUSY;
                        div_start_n = 1'b1;
                    end else begin
                        state_n      = MUL_BUSY;
                        mult_start_n = 1'b1;
                    end
`else
                    if (bus.op[1]) begin
                        state_n     = DIV_BUSY;
                        div_start_n = 1'b1;
                    end else begin
                        state_n      = MUL_BUSY;
                        mult_start_n = 1'b1;
                    end
`endif
                end
            end
            MUL_BUSY, DIV_BUSY: begin
                cnt_n = cnt + CNT_W'(1);
                if (bus.flush) begin
                    state_n = IDLE;
                end else if (unit_done) begin
                    state_n = WRITE;
                    we_n    = 1'b1;
                    hi_n    = unit_res[2*XLEN-1:XLEN];
                    lo_n    = unit_res[XLEN-1:0];
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                    tmo_n   = 1'b1;
                end
            end
            WRITE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.mult_start  <= 1'b0;
            bus.div_start   <= 1'b0;
            bus.op_a        <= '0;
            bus.op_b        <= '0;
            bus.op_signed   <= 1'b0;
            bus.hi_we       <= 1'b0;
            bus.lo_we       <= 1'b0;
            bus.hi_wdata    <= '0;
            bus.lo_wdata    <= '0;
            bus.timeout_err <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            bus.mult_start  <= mult_start_n;
            bus.div_start   <= div_start_n;
            bus.op_a        <= op_a_n;
            bus.op_b        <= op_b_n;
            bus.op_signed   <= op_signed_n;
            bus.hi_we       <= we_n;
            bus.lo_we       <= we_n;
            bus.hi_wdata    <= hi_n;
            bus.lo_wdata    <= lo_n;
            bus.timeout_err <= tmo_n;
            bus.busy        <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected starts, writes and
// watchdog aborts into queues; a negedge monitor pops and compares them.
module tb_muldiv_ctrl;
    logic clk;
    logic rst;

    muldiv_if bus ();

    muldiv_ctrl #(.TIMEOUT(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
    } start_t;

    start_t      start_q[$];
    logic [63:0] wr_q[$];
    bit          tmo_q[$];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Monitor: compare every start pulse, HI/LO write and abort against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mult_start || bus.div_start) begin
                if (start_q.size() == 0) begin
                    chk("start_unexpected", {62'd0, bus.div_start, bus.mult_start}, 64'd0);
                end else begin
                    start_t s;
                    s = start_q.pop_front();
                    chk("start_unit", {62'd0, bus.div_start, bus.mult_start},
                        s.is_div ? 64'd2 : 64'd1);
                    chk("start_ops", {bus.op_a, bus.op_b}, {s.a, s.b});
                    chk("start_signed", {63'd0, bus.op_signed}, {63'd0, s.sgn});
                end
            end
            if (bus.hi_we || bus.lo_we) begin
                chk("we_pair", {63'd0, bus.lo_we}, {63'd0, bus.hi_we});
                if (wr_q.size() == 0) begin
                    chk("write_unexpected", {bus.hi_wdata, bus.lo_wdata}, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    logic [63:0] w;
                    w = wr_q.pop_front();
                    chk("hilo_write", {bus.hi_wdata, bus.lo_wdata}, w);
                end
            end
            if (bus.timeout_err) begin
                if (tmo_q.size() == 0) chk("timeout_unexpected", 64'd1, 64'd0);
                else begin
                    void'(tmo_q.pop_front());
                    chk("timeout_busy", {63'd0, bus.busy}, 64'd0);
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1;
        bus.op_valid = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
        bus.hilo_read = 0; bus.flush = 0;
        bus.mult_done = 0; bus.mult_result = 0; bus.div_done = 0; bus.div_result = 0;
        tick(2);
        at_neg();
        chk("reset_ctl", {56'd0, bus.mult_start, bus.div_start, bus.op_signed, bus.stall,
                          bus.hi_we, bus.lo_we, bus.timeout_err, bus.busy}, 64'd0);
        chk("reset_ops", {bus.op_a, bus.op_b}, 64'd0);
        tick();
        rst = 1'b0;

        // 1: signed MULT -2 * 3, done 4 cycles after start.
        bus.op_valid = 1; bus.op = 2'b00; bus.rs_data = 32'hFFFF_FFFE; bus.rt_data = 32'd3;
        start_q.push_back('{1'b0, 32'hFFFF_FFFE, 32'd3, 1'b1});
        tick();
        bus.op_valid = 0;
        at_neg();
        chk("t1_start", {62'd0, bus.mult_start, bus.busy}, 64'd3);
        tick();
        at_neg();
        chk("t1_start_pulse", {63'd0, bus.mult_start}, 64'd0);
        tick(3);
        bus.mult_done = 1; bus.mult_result = 64'hFFFF_FFFF_FFFF_FFFA;
        wr_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
        tick();
        bus.mult_done = 0;
        at_neg();
        chk("t1_write_at_start_plus5", {63'd0, bus.hi_we}, 64'd1);
        tick();
        at_neg();
        chk("t1_idle", {62'd0, bus.hi_we, bus.busy}, 64'd0);
        chk("t1_wdata_hold", {bus.hi_wdata, bus.lo_wdata}, 64'hFFFF_FFFF_FFFF_FFFA);

        // 2: DIVU 100/7 with a MULT waiting behind it.
        bus.op_valid = 1; bus.op = 2'b11; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
        start_q.push_back('{1'b1, 32'd100, 32'd7, 1'b0});
        tick();
        bus.op = 2'b00; bus.rs_data = 32'd5; bus.rt_data = 32'd6;
        at_neg();
        chk("t2_stall_busy0", {63'd0, bus.stall}, 64'd1);
        tick();
        at_neg();
        chk("t2_stall_busy1", {63'd0, bus.stall}, 64'd1);
        bus.div_done = 1; bus.div_result = {32'd2, 32'd14};
        wr_q.push_back({32'd2, 32'd14});
        tick();
        bus.div_done = 0;
        start_q.push_back('{1'b0, 32'd5, 32'd6, 1'b1});
        at_neg();
        chk("t2_stall_write", {62'd0, bus.stall, bus.hi_we}, 64'd3);
        tick();
        at_neg();
        chk("t2_idle_no_stall", {62'd0, bus.stall, bus.busy}, 64'd0);
        tick();
        bus.op_valid = 0;
        at_neg();
        chk("t2_second_accepted", {63'd0, bus.mult_start}, 64'd1);
        bus.mult_done = 1; bus.mult_result = 64'd30;
        wr_q.push_back(64'd30);
        tick();
        bus.mult_done = 0;
        tick();

        // 3: hilo_read hazard during DIV_BUSY and WRITE.
        bus.hilo_read = 1;
        bus.op_valid = 1; bus.op = 2'b10; bus.rs_data = 32'd9; bus.rt_data = 32'd3;
        start_q.push_back('{1'b1, 32'd9, 32'd3, 1'b1});
        at_neg();
        chk("t3_idle_no_stall", {63'd0, bus.stall}, 64'd0);
        tick();
        bus.op_valid = 0;
        at_neg();
        chk("t3_stall_div_busy", {63'd0, bus.stall}, 64'd1);
        tick();
        bus.div_done = 1; bus.div_result = {32'd0, 32'd3};
        wr_q.push_back({32'd0, 32'd3});
        tick();
        bus.div_done = 0;
        at_neg();
        chk("t3_stall_write", {62'd0, bus.stall, bus.hi_we}, 64'd3);
        tick();
        at_neg();
        chk("t3_after_write", {63'd0, bus.stall}, 64'd0);
        bus.hilo_read = 0;

        // 4: watchdog abort after 40 busy cycles, late done ignored.
        bus.op_valid = 1; bus.op = 2'b10; bus.rs_data = 32'd10; bus.rt_data = 32'd2;
        start_q.push_back('{1'b1, 32'd10, 32'd2, 1'b1});
        tick();
        bus.op_valid = 0;
        tick(39);
        at_neg();
        chk("t4_last_busy", {62'd0, bus.busy, bus.timeout_err}, 64'd2);
        tmo_q.push_back(1'b1);
        tick();
        at_neg();
        chk("t4_timeout", {61'd0, bus.timeout_err, bus.busy, bus.hi_we}, 64'd4);
        tick();
        bus.div_done = 1; bus.div_result = 64'h1111_1111_2222_2222;
        at_neg();
        chk("t4_tmo_pulse", {63'd0, bus.timeout_err}, 64'd0);
        tick();
        bus.div_done = 0;
        tick();
        at_neg();
        chk("t4_late_done", {62'd0, bus.busy, bus.hi_we}, 64'd0);

        // 5a: flush two cycles into MUL_BUSY, then a stale done.
        bus.op_valid = 1; bus.op = 2'b01; bus.rs_data = 32'd7; bus.rt_data = 32'd8;
        start_q.push_back('{1'b0, 32'd7, 32'd8, 1'b0});
        tick();
        bus.op_valid = 0;
        tick(2);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        at_neg();
        chk("t5_flush_idle", {62'd0, bus.busy, bus.hi_we}, 64'd0);
        bus.mult_done = 1; bus.mult_result = 64'd56;
        tick();
        bus.mult_done = 0;
        at_neg();
        chk("t5_stale_done", {62'd0, bus.busy, bus.hi_we}, 64'd0);
        tick();

        // 5b: reset in the middle of a DIVU.
        bus.op_valid = 1; bus.op = 2'b11; bus.rs_data = 32'd20; bus.rt_data = 32'd4;
        start_q.push_back('{1'b1, 32'd20, 32'd4, 1'b0});
        tick();
        bus.op_valid = 0;
        bus.hilo_read = 1;
        tick();
        rst = 1;
        tick();
        at_neg();
        chk("t5_rst_ctl", {56'd0, bus.mult_start, bus.div_start, bus.op_signed, bus.stall,
                           bus.hi_we, bus.lo_we, bus.timeout_err, bus.busy}, 64'd0);
        chk("t5_rst_ops", {bus.op_a, bus.op_b}, 64'd0);
        chk("t5_rst_wdata", {bus.hi_wdata, bus.lo_wdata}, 64'd0);
        rst = 0;
        bus.hilo_read = 0;
        bus.div_done = 1; bus.div_result = 64'h0000_0000_0000_0005;
        tick();
        bus.div_done = 0;
        tick();

        // 6: DIV by zero.
        bus.op_valid = 1; bus.op = 2'b10; bus.rs_data = 32'd55; bus.rt_data = 32'd0;
`ifdef DIV_ZERO_BYPASS_EN
        wr_q.push_back({32'd55, 32'hFFFF_FFFF});
        tick();
        bus.op_valid = 0;
        at_neg();
        chk("t6_bypass_write", {61'd0, bus.div_start, bus.hi_we, bus.busy}, 64'd3);
        tick();
`else
        start_q.push_back('{1'b1, 32'd55, 32'd0, 1'b1});
        tick();
        bus.op_valid = 0;
        at_neg();
        chk("t6_div_start", {63'd0, bus.div_start}, 64'd1);
        bus.div_done = 1; bus.div_result = 64'h0000_0037_FFFF_FFFF;
        wr_q.push_back(64'h0000_0037_FFFF_FFFF);
        tick();
        bus.div_done = 0;
        at_neg();
        chk("t6_write", {63'd0, bus.hi_we}, 64'd1);
        tick();
`endif
        tick(2);
        at_neg();
        chk("end_idle", {63'd0, bus.busy}, 64'd0);
        chk("start_q_drained", 64'(start_q.size()), 64'd0);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        chk("tmo_q_drained", 64'(tmo_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the multi-cycle multiplier and divider that feed HI/LO.
- Accepts MULT/MULTU/DIV/DIVU from EX, latches the operands and launches the selected unit with a one-cycle start pulse.
- Waits for that unit's done, then issues a single HI/LO write.
- Stalls the pipeline on structural (second mul/div) and data (MFHI/MFLO) hazards; supports flush and a watchdog timeout.

Parameters:
TIMEOUT, 40, max busy cycles waited for done before abort (>=2)
CNT_W, $clog2(TIMEOUT)+1, busy-cycle counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
op_valid  in  1  EX holds a mul/div instruction
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_data  in  32  operand A / dividend
rt_data  in  32  operand B / divisor
hilo_read  in  1  ID/EX instruction reads HI or LO
flush  in  1  pipeline flush (exception/branch cancel)
mult_done  in  1  multiplier result valid (1-cycle pulse)
mult_result  in  64  {hi,lo} product
div_done  in  1  divider result valid (1-cycle pulse)
div_result  in  64  {remainder,quotient}
mult_start  out  1  1-cycle launch pulse to multiplier
div_start  out  1  1-cycle launch pulse to divider
op_a  out  32  registered operand A, stable while busy
op_b  out  32  registered operand B, stable while busy
op_signed  out  1  1 for MULT/DIV
stall  out  1  hold IF/ID/EX
hi_we  out  1  HI write enable
lo_we  out  1  LO write enable
hi_wdata  out  32  HI write data
lo_wdata  out  32  LO write data
timeout_err  out  1  1-cycle pulse on watchdog abort
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, result register 0. Reset mid-operation drops the op; no HI/LO write.
- States: IDLE, MUL_BUSY, DIV_BUSY, WRITE.
- IDLE:
  - op_valid && !flush at edge T: latch rs/rt into op_a/op_b, op_signed = !op[0].
  - At T+1: state = MUL_BUSY (op[1]=0) or DIV_BUSY (op[1]=1); matching start = 1 for that cycle only; counter cleared.
  - op_valid && flush: not accepted.
- MUL_BUSY / DIV_BUSY:
  - Counter increments each cycle.
  - Matching done: capture result, next state WRITE. The other unit's done is ignored.
  - Counter == TIMEOUT-1 without done: timeout_err pulse, next IDLE, no write. If done and timeout coincide, done wins.
  - flush: next IDLE, no write; a later done for the aborted op is ignored.
- WRITE:
  - hi_we = lo_we = 1 for exactly one cycle; hi_wdata/lo_wdata = captured result[63:32]/[31:0].
  - Next IDLE. flush is ignored in WRITE (the op has committed).
  - hi_wdata/lo_wdata hold their last value while we = 0.
- Latency: accept at T, start at T+1, done at T+1+k, write at T+2+k. The next op can be accepted at T+3+k.
- stall = (state != IDLE) && (op_valid || hilo_read); combinational.
  - Asserted in WRITE too, since HI/LO are visible the cycle after the write.
  - No stall in IDLE.
- op_a/op_b/op_signed change only on acceptance.

Optional Feature:
DIV_ZERO_BYPASS_EN
- Defined: a DIV/DIVU accepted with rt_data == 0 skips the divider. No div_start; state goes IDLE -> WRITE at T+1; hi_wdata = rs_data, lo_wdata = 32'hFFFFFFFF; write at T+1.
- Undefined: a divide by zero launches the divider like any other op; the result is whatever div_result returns.

Test Plan:
1. MULT rs=32'hFFFFFFFE (-2), rt=3, mult_done 4 cycles after start with 64'hFFFFFFFF_FFFFFFFA -> mult_start single pulse, op_signed=1, hi_we/lo_we at start+5, hi=FFFFFFFF, lo=FFFFFFFA.
2. DIVU rs=100, rt=7, div_done with {2,14} -> div_start pulse, op_signed=0, HI=2, LO=14; a second MULT arriving while busy -> stall=1 until IDLE, accepted the cycle after WRITE.
3. hilo_read=1 during DIV_BUSY and WRITE -> stall=1 in both; stall=0 the cycle after WRITE.
4. TIMEOUT=40, DIV with no div_done -> timeout_err pulse after 40 busy cycles, no hi_we, busy=0 next cycle; a late div_done is ignored.
5. flush 2 cycles into MUL_BUSY, then mult_done -> no write, state IDLE. rst asserted mid-DIV -> all outputs 0 next cycle.
6. DIV_ZERO_BYPASS_EN defined, DIV rs=55, rt=0 -> no div_start, write at T+1 with HI=55, LO=FFFFFFFF. Undefined -> div_start issued.
